// File: rtl/uart_if.sv
// Receive-side UART signal bundle: serial line, flow control and the decoded byte.
interface uart_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic                 rx;
   logic                 rts;
   logic                 cts;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_data_ready;

   modport slave (
      input  rx,
      input  rts,
      output cts,
      output rx_data,
      output rx_data_ready
   );

   modport master (
      output rx,
      output rts,
      input  cts,
      input  rx_data,
      input  rx_data_ready
   );
endinterface

// File: rtl/uart.sv
// Receive-only 8N1 UART clocked at the baud rate (one sample per bit), with an
// input synchroniser, optional line inversion and a one-cycle byte strobe.
module uart #(
   parameter int unsigned DATA_BITS   = 8,
   parameter bit          RX_INVERTED = 1'b1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic   clock_115200hz,
   input  logic   reset,
   uart_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      STOP,
      WAIT_IDLE
   } state_e;

   state_e               state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_data_ready_q, rx_data_ready_d;
   logic                 cts_q, cts_d;
   logic                 unused_rts_q, unused_rts_d;
   logic                 line_c;

   // Oldest synchroniser stage is the decoded, logical-polarity line.
   assign line_c = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clock_115200hz) begin
      if (reset) begin
         state_q         <= IDLE;
         sync_q          <= '1;
         bitcnt_q        <= '0;
         shift_q         <= '0;
         rx_data_q       <= '0;
         rx_data_ready_q <= 1'b0;
         cts_q           <= 1'b0;
         unused_rts_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         sync_q          <= sync_d;
         bitcnt_q        <= bitcnt_d;
         shift_q         <= shift_d;
         rx_data_q       <= rx_data_d;
         rx_data_ready_q <= rx_data_ready_d;
         cts_q           <= cts_d;
         unused_rts_q    <= unused_rts_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      bitcnt_d        = bitcnt_q;
      shift_d         = shift_q;
      rx_data_d       = rx_data_q;
      rx_data_ready_d = 1'b0;
      unused_rts_d    = bus.rts;
      sync_d          = {sync_q[SYNC_STAGES-2:0], bus.rx ^ RX_INVERTED};

      unique case (state_q)
         IDLE: begin
            if (!line_c) begin
               bitcnt_d = '0;
               state_d  = DATA;
            end
         end
         DATA: begin
            // LSB arrives first, so shift in from the top.
            shift_d  = {line_c, shift_q[DATA_BITS-1:1]};
            bitcnt_d = bitcnt_q + CNT_W'(1);
            if (bitcnt_q == CNT_W'(DATA_BITS - 1)) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (line_c) begin
               rx_data_d       = shift_q;
               rx_data_ready_d = 1'b1;
               state_d         = IDLE;
            end else begin
               state_d = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            // Hold off until the line idles so a break is not seen as 0x00 frames.
            if (line_c) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      cts_d = (state_d == IDLE);
   end

   assign bus.cts           = cts_q;
   assign bus.rx_data       = rx_data_q;
   assign bus.rx_data_ready = rx_data_ready_q;
endmodule

// File: tb/tb_uart.sv
// Directed bench for the inverted-line UART receiver; expected bytes and strobe
// cycles are queued when a frame is driven and matched when the strobe appears.
module tb_uart;
   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_if u_if ();

   uart u_dut (
      .clock_115200hz (clk),
      .reset          (reset),
      .bus            (u_if)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Strobe monitor: every strobe must match the oldest queued byte and cycle.
   always @(negedge clk) begin
      if (reset === 1'b0 && u_if.rx_data_ready !== 1'b0) begin
         chk("strobe_expected", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("strobe_level", 32'(u_if.rx_data_ready), 32'd1);
            chk("rx_data", 32'(u_if.rx_data), 32'(e.data));
            chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         u_if.rx = 1'b0;
      end
   endtask

   // Drive one inverted 8N1 frame, one bit per clock; bad_stop holds a
   // logical-0 stop bit for 5 cycles.
   task automatic send_frame(input logic [7:0] b, input bit push, input bit bad_stop,
                             input bit rts_rand);
      exp_t e;
      @(negedge clk);
      u_if.rx = 1'b1;
      if (push) begin
         e.data = b;
         e.cyc  = cyc + 12;
         sb.push_back(e);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         u_if.rx = ~b[i];
         if (rts_rand) u_if.rts = 1'($urandom_range(0, 1));
         if (i == 4) chk("cts_in_frame", 32'(u_if.cts), 32'd0);
      end
      if (!bad_stop) begin
         @(negedge clk);
         u_if.rx = 1'b0;
      end else begin
         repeat (5) begin
            @(negedge clk);
            u_if.rx = 1'b1;
         end
         chk("cts_wait_idle", 32'(u_if.cts), 32'd0);
      end
   endtask

   initial begin
      u_if.rx  = 1'b0;
      u_if.rts = 1'b0;
      reset    = 1'b1;

      repeat (4) begin
         @(negedge clk);
         chk("rst_rx_data", 32'(u_if.rx_data), 32'd0);
         chk("rst_ready", 32'(u_if.rx_data_ready), 32'd0);
         chk("rst_cts", 32'(u_if.cts), 32'd0);
      end
      reset = 1'b0;
      @(negedge clk);
      chk("cts_after_reset", 32'(u_if.cts), 32'd1);

      idle(2);
      send_frame(8'h59, 1'b1, 1'b0, 1'b0);
      idle(4);
      chk("hold_0x59", 32'(u_if.rx_data), 32'h59);
      chk("cts_idle", 32'(u_if.cts), 32'd1);

      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      idle(4);
      chk("b2b_drained", 32'(sb.size()), 32'd0);
      chk("hold_0x3C", 32'(u_if.rx_data), 32'h3C);

      send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
      idle(4);
      chk("framing_keep", 32'(u_if.rx_data), 32'h3C);
      chk("cts_recovered", 32'(u_if.cts), 32'd1);
      send_frame(8'h01, 1'b1, 1'b0, 1'b0);
      idle(4);
      chk("hold_0x01", 32'(u_if.rx_data), 32'h01);

      // Abort a 0x3C frame with reset while data bit 4 is on the line.
      @(negedge clk);
      u_if.rx = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         u_if.rx = ~(i[1:0] == 2'd2 || i[1:0] == 2'd3);
      end
      @(negedge clk);
      u_if.rx = 1'b0;
      reset   = 1'b1;
      repeat (2) begin
         @(negedge clk);
         u_if.rx = 1'b0;
         chk("abort_rx_data", 32'(u_if.rx_data), 32'd0);
         chk("abort_ready", 32'(u_if.rx_data_ready), 32'd0);
      end
      reset = 1'b0;
      idle(14);
      chk("abort_no_data", 32'(u_if.rx_data), 32'd0);
      chk("abort_cts", 32'(u_if.cts), 32'd1);
      send_frame(8'h80, 1'b1, 1'b0, 1'b0);
      idle(4);
      chk("hold_0x80", 32'(u_if.rx_data), 32'h80);

      send_frame(8'h59, 1'b1, 1'b0, 1'b1);
      idle(4);
      chk("rts_rx_data", 32'(u_if.rx_data), 32'h59);
      chk("final_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart.md
Name: uart

Overview:
- Receive-only UART front end with hardware flow-control pins, clocked directly at the baud rate (one clock per bit, 115200 Hz).
- Deserialises 8N1 frames from an inverted-polarity serial line: line idle = physical 0, start bit = physical 1, data bits inverted, stop bit = physical 0.
- Presents each received byte with a one-cycle ready strobe to the LED-actor logic.

Parameters:
- DATA_BITS, 8, number of data bits per frame, sent LSB first.
- RX_INVERTED, 1, when 1 the rx pin is inverted before decoding; when 0 the line uses standard polarity (idle high).
- SYNC_STAGES, 2, flip-flop depth of the rx input synchroniser (minimum 2).

Ports:
- clock_115200hz  input  1  baud-rate clock; all logic uses its rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  serial receive line (asynchronous; polarity set by RX_INVERTED).
- rts  input  1  peer request-to-send; registered only, does not affect the receive path (reserved for a future transmitter).
- cts  output  1  clear-to-send; 1 when the receiver is idle and can accept a new frame.
- rx_data  output  DATA_BITS  last correctly framed byte.
- rx_data_ready  output  1  one-cycle strobe: rx_data has just been updated.

Behaviour:
- All registers update on posedge clock_115200hz. Reset is synchronous and active-high.
- Reset values:
  - rx_data = 0, rx_data_ready = 0, cts = 0, state = IDLE.
  - Bit counter and shift register = 0.
  - Synchroniser flops = logical idle (1 after inversion).
- Reset asserted mid-frame aborts the frame: no strobe, and rx_data is cleared.
- Input path:
  - line = rx XOR RX_INVERTED, passed through SYNC_STAGES flops.
  - The FSM acts on the synchroniser output, so latency is SYNC_STAGES cycles from pin to decode.
- FSM states: IDLE, DATA, STOP, WAIT_IDLE.
  - IDLE: cts = 1. A synced line of 0 (start bit) sets bitcnt = 0 and moves to DATA; otherwise stay.
  - DATA: each cycle shift the synced line into the MSB of the shift register (LSB-first reception) and increment bitcnt. After DATA_BITS samples, go to STOP.
  - STOP, synced line 1: rx_data <= shift register, rx_data_ready <= 1 for exactly one cycle, go to IDLE.
  - STOP, synced line 0 (framing error): discard the byte, rx_data unchanged, no strobe, go to WAIT_IDLE.
  - WAIT_IDLE: stay until the synced line is 1, then go to IDLE. This prevents a break condition from being decoded as repeated 0x00 frames.
- cts is registered and is 0 in DATA, STOP and WAIT_IDLE.
- Timing: if physical start bit is first sampled at edge t0, then:
  - FSM sees the start bit at edge t0+2.
  - Data bit i is captured at edge t0+3+i.
  - The stop bit is checked at edge t0+11.
  - rx_data and rx_data_ready are valid in the cycle after edge t0+11.
  - (Assumes SYNC_STAGES = 2, DATA_BITS = 8.)
- Back-to-back frames: a new start bit may be detected in the first IDLE cycle after STOP. The strobe and the new frame's DATA entry never conflict.
- rx_data holds its value between strobes.
- rts is sampled into a register and has no other effect.

Test Plan:
- Reset held 4 cycles with rx = 0 -> rx_data = 0x00, rx_data_ready = 0, cts = 0 during reset; cts = 1 in the first cycle after reset releases.
- Inverted frame for 0x59: rx = 1 (start), then ~bits of 01011001 LSB first, then 0 (stop), one bit per clock -> rx_data = 0x59 and rx_data_ready high for exactly 1 cycle, 12 cycles after start-bit sampling; cts low during the frame.
- Two back-to-back frames 0xA5 then 0x3C with no idle gap -> two strobes 10 cycles apart carrying 0xA5 then 0x3C.
- Frame 0xFF with stop bit held physical 1 for 5 cycles -> no strobe, rx_data keeps its previous value; FSM waits in WAIT_IDLE until the line idles; the next valid frame 0x01 is received correctly.
- Reset asserted at data bit 4 of a frame -> no strobe, rx_data = 0; the next full frame 0x80 is received normally.
- rts toggled randomly during a 0x59 frame -> identical rx_data and timing as with rts constant.
